// File: rtl/toggle_hs_pkg.sv
// Shared definitions for the two-phase toggle handshake (receive and transmit ends).
package toggle_hs_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } hs_state_e;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int SYNC_MIN        = 2;
   localparam int SYNC_MAX        = 4;

endpackage

// File: rtl/toggle_sync.sv
// N-flop single-bit synchroniser with synchronous clear; used for req_tog here and ack_tog on the sender.
module toggle_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [N-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[N-2:0], d_i};
      end
   end

   assign q_o = sync_q[N-1];

endmodule

// File: rtl/toggle_handshake_rx.sv
// Receive end of the two-phase toggle handshake: detect req_tog flips, capture the word,
// offer it on valid/ready and return ack_tog once it has been consumed.
//
//  state | meaning
//  IDLE  | no word held; waiting for synchronised req_tog to differ from req_seen
//  HOLD  | word held in out_data, out_valid high until out_ready
module toggle_handshake_rx
   import toggle_hs_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_tog,
   input  logic [DATA_W-1:0] req_data,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              ack_tog,
   output logic [CNT_W-1:0]  evt_cnt,
   output logic              overrun
);

   if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("toggle_handshake_rx: SYNC_STAGES out of range");
   end

   hs_state_e         state_q, state_d;
   logic              req_s;
   logic              req_seen_q, req_seen_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ack_q, ack_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovr_q, ovr_d;
   logic              req_evt;

   toggle_sync #(.N(SYNC_STAGES)) u_req_sync (
      .clk (clk),
      .rst (rst),
      .d_i (req_tog),
      .q_o (req_s)
   );

   assign req_evt = (req_s != req_seen_q);

   always_comb begin
      state_d    = state_q;
      req_seen_d = req_seen_q;
      data_d     = data_q;
      ack_d      = ack_q;
      cnt_d      = cnt_q;
      ovr_d      = ovr_q;
      unique case (state_q)
         IDLE: begin
            if (req_evt) begin
               data_d     = req_data;
               req_seen_d = req_s;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            // A flip arriving while a word is held means the sender did not wait for ack.
            if (req_evt) begin
               ovr_d = 1'b1;
            end
            if (out_ready) begin
               ack_d   = ~ack_q;
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         req_seen_q <= 1'b0;
         data_q     <= '0;
         ack_q      <= 1'b0;
         cnt_q      <= '0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_seen_q <= req_seen_d;
         data_q     <= data_d;
         ack_q      <= ack_d;
         cnt_q      <= cnt_d;
         ovr_q      <= ovr_d;
      end
   end

   assign out_valid = (state_q == HOLD);
   assign out_data  = data_q;
   assign ack_tog   = ack_q;
   assign evt_cnt   = cnt_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Bench for toggle_handshake_rx: vector table, hand-written corner sequences and a randomised stream.
module tb_toggle_handshake_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_tog;
   logic [7:0] req_data;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       ack_tog;
   logic [7:0] evt_cnt;
   logic       overrun;

   int n_cmp  = 0;
   int n_fail = 0;

   toggle_handshake_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_tog   (req_tog),
      .req_data  (req_data),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .ack_tog   (ack_tog),
      .evt_cnt   (evt_cnt),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       tog;
      logic [7:0] data;
      logic       rdy;
      logic       v;
      logic [7:0] d;
      logic       ack;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic tog, input logic [7:0] data, input logic rdy,
                               input logic v, input logic [7:0] d, input logic ack,
                               input logic [7:0] cnt);
      vec_t r;
      r.tog = tog; r.data = data; r.rdy = rdy;
      r.v = v; r.d = d; r.ack = ack; r.cnt = cnt;
      vecs.push_back(r);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int         n;
      int         sent;
      int         consumed;
      int         cyc;
      logic       last_ack;
      logic       fired;
      logic [7:0] q[$];

      // single word A5 with ready high, then 3C held off for 10 cycles
      for (int i = 0; i < 2; i++) add(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0);
      add(1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 8'd0);
      add(1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 8'd1);
      add(1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 8'd1);
      for (int i = 0; i < 2; i++) add(1'b0, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 8'd1);
      for (int i = 0; i < 8; i++) add(1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 8'd1);
      add(1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 8'd2);
      add(1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 8'd2);

      rst = 1'b1; req_tog = 1'b0; req_data = 8'h00; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_ack", ack_tog, 1'b0);
      chk("rst_cnt", evt_cnt, 8'd0);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_data", out_data, 8'h00);
      rst = 1'b0;

      foreach (vecs[i]) begin
         req_tog = vecs[i].tog; req_data = vecs[i].data; out_ready = vecs[i].rdy;
         tick();
         chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].v);
         chk($sformatf("vec%0d_data", i), out_data, vecs[i].d);
         chk($sformatf("vec%0d_ack", i), ack_tog, vecs[i].ack);
         chk($sformatf("vec%0d_cnt", i), evt_cnt, vecs[i].cnt);
         chk($sformatf("vec%0d_ovr", i), overrun, 1'b0);
      end

      // overrun: second flip before ack
      req_data = 8'h11; req_tog = 1'b1; out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin tick(); n++; end
      chk("ovr_cap_lat", n, 3);
      chk("ovr_cap_data", out_data, 8'h11);
      req_data = 8'h22; req_tog = 1'b0;
      n = 0;
      while (!overrun && n < 10) begin tick(); n++; end
      chk("ovr_flag_lat", n, 3);
      chk("ovr_hold_valid", out_valid, 1'b1);
      chk("ovr_hold_data", out_data, 8'h11);
      out_ready = 1'b1;
      tick();
      chk("ovr_c1_valid", out_valid, 1'b0);
      chk("ovr_c1_ack", ack_tog, 1'b1);
      chk("ovr_c1_cnt", evt_cnt, 8'd3);
      tick();
      chk("ovr_cap2_valid", out_valid, 1'b1);
      chk("ovr_cap2_data", out_data, 8'h22);
      tick();
      chk("ovr_c2_valid", out_valid, 1'b0);
      chk("ovr_c2_ack", ack_tog, 1'b0);
      chk("ovr_c2_cnt", evt_cnt, 8'd4);
      chk("ovr_sticky", overrun, 1'b1);
      repeat (4) tick();
      chk("ovr_sticky_late", overrun, 1'b1);

      // reset while a word is held, req_tog left at 1
      out_ready = 1'b0; req_data = 8'h77; req_tog = 1'b1;
      n = 0;
      while (!out_valid && n < 10) begin tick(); n++; end
      chk("mid_cap_lat", n, 3);
      chk("mid_cap_data", out_data, 8'h77);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_cnt", evt_cnt, 8'd0);
      chk("mid_rst_ack", ack_tog, 1'b0);
      chk("mid_rst_ovr", overrun, 1'b0);
      chk("mid_rst_data", out_data, 8'h00);
      n = 0;
      while (!out_valid && n < 10) begin tick(); n++; end
      chk("mid_recap_lat", n, 3);
      chk("mid_recap_data", out_data, 8'h77);
      out_ready = 1'b1;
      tick();
      chk("mid_c_ack", ack_tog, 1'b1);
      chk("mid_c_cnt", evt_cnt, 8'd1);

      // sender reset alongside receiver
      rst = 1'b1; req_tog = 1'b0; out_ready = 1'b0;
      tick();
      rst = 1'b0;
      chk("rst2_ack", ack_tog, 1'b0);
      chk("rst2_cnt", evt_cnt, 8'd0);
      repeat (4) tick();
      chk("rst2_idle_valid", out_valid, 1'b0);

      // 300-word stream: sender flips on each ack flip, consumer ready is random
      sent = 0; consumed = 0; cyc = 0;
      last_ack = ack_tog;
      req_data = 8'($urandom); q.push_back(req_data); req_tog = ~req_tog; sent = 1;
      while (consumed < 300 && cyc < 20000) begin
         out_ready = 1'($urandom_range(0, 1));
         fired = 1'b0;
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("strm_spurious_word", 1, 0);
            else chk("strm_data", out_data, q.pop_front());
            consumed++;
            fired = 1'b1;
         end
         tick();
         cyc++;
         if (fired) begin
            chk("strm_cnt", evt_cnt, consumed % 256);
            chk("strm_ack", ack_tog, consumed % 2);
         end
         if (ack_tog != last_ack) begin
            last_ack = ack_tog;
            if (sent < 300) begin
               req_data = 8'($urandom);
               q.push_back(req_data);
               req_tog = ~req_tog;
               sent++;
            end
         end
      end
      chk("strm_consumed", consumed, 300);
      chk("strm_queue_empty", q.size(), 0);
      chk("strm_final_cnt", evt_cnt, 8'd44);
      chk("strm_overrun", overrun, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
